// File: rtl/regfile_wb_ctrl.sv
// Write-back controller: buffers ALU/load write requests in a shared in-order FIFO
// and issues up to two register-file writes per cycle, never two to the same register.
module regfile_wb_ctrl #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    a_valid,
   output logic                    a_ready,
   input  logic [ADDR_W-1:0]       a_addr,
   input  logic [DATA_W-1:0]       a_data,
   input  logic                    b_valid,
   output logic                    b_ready,
   input  logic [ADDR_W-1:0]       b_addr,
   input  logic [DATA_W-1:0]       b_data,
   output logic [ADDR_W:0]         wb_sel0,
   output logic [DATA_W-1:0]       wb_data0,
   output logic [ADDR_W:0]         wb_sel1,
   output logic [DATA_W-1:0]       wb_data1,
   output logic [(2**ADDR_W)-1:0]  pending,
   output logic [$clog2(DEPTH):0]  count
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [ADDR_W-1:0] addr_q [DEPTH];
   logic [ADDR_W-1:0] addr_d [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [DATA_W-1:0] data_d [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [ADDR_W:0]   sel0_q, sel0_d;
   logic [ADDR_W:0]   sel1_q, sel1_d;
   logic [DATA_W-1:0] wdata0_q, wdata0_d;
   logic [DATA_W-1:0] wdata1_q, wdata1_d;

   logic              push_a, push_b;
   logic              pop0, pop1;
   logic [PTR_W-1:0]  head1_ptr;
   logic [PTR_W-1:0]  b_ptr;
   logic [PTR_W-1:0]  off;

   // Readiness looks only at registered occupancy, never at valid or same-cycle pops.
   always_comb begin
      a_ready = (count_q <= CNT_W'(DEPTH - 1));
      b_ready = (count_q <= CNT_W'(DEPTH - 2));
      push_a  = a_valid & a_ready;
      push_b  = b_valid & b_ready;
   end

   // Head+1 is held back when it targets the same register as the head.
   always_comb begin
      head1_ptr = rd_ptr_q + PTR_W'(1);
      pop0      = (count_q != '0);
      pop1      = (count_q >= CNT_W'(2)) && (addr_q[head1_ptr] != addr_q[rd_ptr_q]);
   end

   always_comb begin
      addr_d   = addr_q;
      data_d   = data_q;
      b_ptr    = push_a ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
      if (push_a) begin
         addr_d[wr_ptr_q] = a_addr;
         data_d[wr_ptr_q] = a_data;
      end
      if (push_b) begin
         addr_d[b_ptr] = b_addr;
         data_d[b_ptr] = b_data;
      end
      wr_ptr_d = wr_ptr_q + PTR_W'(push_a) + PTR_W'(push_b);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop0) + PTR_W'(pop1);
      count_d  = count_q + CNT_W'(push_a) + CNT_W'(push_b) - CNT_W'(pop0) - CNT_W'(pop1);

      sel0_d   = {1'b0, sel0_q[ADDR_W-1:0]};
      wdata0_d = wdata0_q;
      sel1_d   = {1'b0, sel1_q[ADDR_W-1:0]};
      wdata1_d = wdata1_q;
      if (pop0) begin
         sel0_d   = {1'b1, addr_q[rd_ptr_q]};
         wdata0_d = data_q[rd_ptr_q];
      end
      if (pop1) begin
         sel1_d   = {1'b1, addr_q[head1_ptr]};
         wdata1_d = data_q[head1_ptr];
      end
   end

   always_comb begin
      pending = '0;
      off     = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         off = PTR_W'(i) - rd_ptr_q;
         if ({1'b0, off} < count_q) pending[addr_q[i]] = 1'b1;
      end
      if (sel0_q[ADDR_W]) pending[sel0_q[ADDR_W-1:0]] = 1'b1;
      if (sel1_q[ADDR_W]) pending[sel1_q[ADDR_W-1:0]] = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q   <= '{default: '0};
         data_q   <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         sel0_q   <= '0;
         sel1_q   <= '0;
         wdata0_q <= '0;
         wdata1_q <= '0;
      end else begin
         addr_q   <= addr_d;
         data_q   <= data_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         sel0_q   <= sel0_d;
         sel1_q   <= sel1_d;
         wdata0_q <= wdata0_d;
         wdata1_q <= wdata1_d;
      end
   end

   assign wb_sel0  = sel0_q;
   assign wb_data0 = wdata0_q;
   assign wb_sel1  = sel1_q;
   assign wb_data1 = wdata1_q;
   assign count    = count_q;

endmodule

// File: doc/regfile_wb_ctrl.md
Name: regfile_wb_ctrl

Overview:
Write-back controller that drives the two write ports of the 16x32 register file. It accepts write requests from two producers (port A: ALU, port B: load unit) through valid/ready handshakes. Requests are buffered in a shared in-order FIFO and issued up to two per cycle as registered `{enable, addr}` selects and data. The controller never issues two writes to the same register in one cycle; the register file drops such a write because its enable is S0 XOR S1. A per-register pending bitmap is exported for hazard detection.

Parameters:
DEPTH, 4, FIFO entries; power of 2, at least 2.
DATA_W, 32, write data width.
ADDR_W, 4, register index width (16 registers).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
a_valid  in  1  port A request valid.
a_ready  out  1  port A may push.
a_addr  in  4  port A destination register.
a_data  in  32  port A write data.
b_valid  in  1  port B request valid.
b_ready  out  1  port B may push.
b_addr  in  4  port B destination register.
b_data  in  32  port B write data.
wb_sel0  out  5  [4] write enable, [3:0] register index; drives file write port 0.
wb_data0  out  32  write data, port 0.
wb_sel1  out  5  same format as wb_sel0; drives file write port 1.
wb_data1  out  32  write data, port 1.
pending  out  16  bit r = 1 while a write to register r is buffered or being issued.
count  out  3  FIFO occupancy (clog2(DEPTH)+1 bits).

Behaviour:
- Reset (async, any time, including mid-stream):
  - count = 0; read and write pointers = 0.
  - wb_sel0 = wb_sel1 = 5'b0; wb_data0 = wb_data1 = 0.
  - pending = 0.
  - All buffered requests are discarded.
- Ready signals (combinational from registered count only):
  - a_ready = (count <= DEPTH-1).
  - b_ready = (count <= DEPTH-2).
  - Neither depends on valid or on same-cycle pops.
- Push: a transfer occurs when valid & ready at the rising edge.
  - If A and B both transfer in the same cycle, A is the older entry: A at wr_ptr, B at wr_ptr+1.
  - If only B transfers, B goes to wr_ptr.
  - Pointers wrap modulo DEPTH.
- Pop (decided from pre-edge FIFO state):
  - count = 0: wb_sel0[4] <= 0, wb_sel1[4] <= 0.
  - count >= 1: head issues on slot 0.
  - Head+1 also issues on slot 1 only if count >= 2 and its addr differs from the head addr; otherwise wb_sel1[4] <= 0 and head+1 stays at the head for the next cycle.
  - Order between writes to the same register is always preserved: older issues first.
  - A disabled slot keeps its previous data and index bits; only [4] is forced to 0.
- Latency:
  - Request accepted at edge N into an empty FIFO appears on wb_sel/wb_data after edge N+1.
  - The register file captures it at edge N+2.
- count update: next count = count + pushes - pops, all from pre-edge values. Push and pop in the same cycle are legal at every level, including full and empty.
- pending[r] (combinational) = OR over valid FIFO entries with addr == r, OR (wb_sel0[4] and wb_sel0[3:0] == r), OR (wb_sel1[4] and wb_sel1[3:0] == r).
- Register file never backpressures. The FIFO fills only through same-address pairs (one pop per cycle). count never exceeds DEPTH.
- Requests on a port with ready = 0 are ignored; the producer must hold the request.

Test Plan:
1. Reset: assert rst asynchronously with 3 entries buffered -> immediately count = 0, pending = 0, wb_sel0 = wb_sel1 = 0; after release a_ready = b_ready = 1 and nothing is issued.
2. Single write: A pushes addr 3, data 0xDEADBEEF at edge N -> after N+1 wb_sel0 = 5'b10011, wb_data0 = 0xDEADBEEF, wb_sel1[4] = 0; pending[3] = 1 from after N until after N+2, then 0.
3. Dual distinct: A pushes (5, 0x1) and B pushes (9, 0x2) in the same cycle -> next cycle wb_sel0 = 5'b10101 with 0x1 and wb_sel1 = 5'b11001 with 0x2; count returns to 0.
4. Same-destination: A pushes (7, 0x11) and B pushes (7, 0x22) -> cycle 1: wb_sel0 = 5'b10111 with 0x11, wb_sel1[4] = 0; cycle 2: wb_sel0 = 5'b10111 with 0x22; register 7 reads 0x22 afterward.
5. Backpressure/wrap: push same-address pairs every cycle for 10 cycles (DEPTH = 4) -> count climbs 2, 3 and holds 3; b_ready = 0 at count 3, a_ready stays 1; issued sequence matches push order exactly across pointer wrap.
6. Mixed: A-only pushes to 1, 2, 3 on consecutive cycles, then stop -> one issue per cycle on slot 0 in order 1, 2, 3; slot 1 never enabled for a single-entry FIFO.
